lcd_seq: RTL and testbench
==========================

LCD_SEQ -- requirements
Module: lcd_seq

Interface
REQ-001 Parameter T_SETUP, default 4: cycles RS/RW/DATA are stable before EN rises.
REQ-002 Parameter T_PULSE, default 12: cycles EN is held high.
REQ-003 Parameter T_HOLD, default 4: cycles RS/RW/DATA are held after EN falls.
REQ-004 Parameter T_EXEC, default 2500: post-command wait in cycles for normal commands.
REQ-005 Parameter T_EXEC_LONG, default 100000: post-command wait in cycles for clear (0x01) and home (0x02) when RS=0.
REQ-006 Parameter T_POWERUP, default 2000000: wait in cycles after reset before the init sequence starts.
REQ-007 Port clk_i, input, 1: sole clock; all logic is on the rising edge.
REQ-008 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-009 Port cmd_valid_i, input, 1: requester offers a command.
REQ-010 Port cmd_rs_i, input, 1: RS of the offered command (0 = instruction, 1 = data).
REQ-011 Port cmd_data_i, input, 8: byte of the offered command.
REQ-012 Port cmd_ready_o, output, 1: FIFO can accept a command.
REQ-013 Port busy_o, output, 1: sequencer not idle, or FIFO not empty.
REQ-014 Port o_io_lcd, output, 12: bit 11 ON, bit 10 EN, bit 9 RS, bit 8 RW (always 0), bits 7:0 DATA.

Function
REQ-015 4-entry command FIFO of {rs, data}; push when cmd_valid_i and cmd_ready_o are both 1.
REQ-016 cmd_ready_o = FIFO not full; a command offered while full is not accepted and stays with the requester.
REQ-017 Push and pop in the same cycle: occupancy unchanged, no data lost; both are legal at any occupancy below 4.
REQ-018 States: PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, EXEC; one shared down-counter of at least 20 bits.
REQ-019 IDLE with FIFO non-empty (init complete): pop the head and latch RS/DATA onto o_io_lcd; enter SETUP next cycle.
REQ-020 IDLE with FIFO empty: remain in IDLE, EN=0.
REQ-021 SETUP: EN=0 for T_SETUP cycles, then PULSE.
REQ-022 PULSE: EN=1 for exactly T_PULSE cycles, then HOLD.
REQ-023 HOLD: EN=0, DATA/RS unchanged for T_HOLD cycles, then EXEC.
REQ-024 EXEC duration: T_EXEC_LONG if the command had RS=0 and data 0x01 or 0x02, else T_EXEC; then IDLE, or INIT if init is incomplete.
REQ-025 DATA and RS change only on entry to SETUP.
REQ-026 EN is high only in PULSE.
REQ-027 ON bit is 1 at all times after reset.
REQ-028 busy_o = (state != IDLE) OR (FIFO count != 0).
REQ-029 Every counter load uses the full parameter value; a parameter value of 0 is treated as 1.
REQ-030 FIFO accepts pushes in every state, including PWR_WAIT and INIT.

Reset
REQ-031 rst_i high at a rising edge: FIFO flushed, counter cleared, state set to PWR_WAIT (IDLE without LCD_INIT_EN).
REQ-032 Output values after reset: o_io_lcd = 12'h800, cmd_ready_o = 1, busy_o = 1 (0 without LCD_INIT_EN).
REQ-033 Reset mid-transfer: EN drops in the cycle after reset is sampled; the in-flight command and all queued commands are discarded.

Configuration
REQ-034 Macro LCD_INIT_EN defined: after reset, wait T_POWERUP cycles in PWR_WAIT, then send 0x38, 0x0C, 0x01, 0x06 (RS=0) through SETUP..EXEC from an internal table, then IDLE.
REQ-035 LCD_INIT_EN defined: the FIFO is not popped until the init sequence completes.
REQ-036 Macro LCD_INIT_EN undefined: no init table and no PWR_WAIT state; reset goes straight to IDLE.

Verification
(Bench parameters: T_SETUP=2, T_PULSE=3, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=40, T_POWERUP=20.)
REQ-037 No LCD_INIT_EN; push {1,0x41} at cycle 0 -> pop at cycle 1; EN high cycles 4-6; DATA=0x41, RS=1 from cycle 2; busy_o low from cycle 19.
REQ-038 No LCD_INIT_EN; push {0,0x01} -> EXEC lasts 40 cycles; a second queued command enters SETUP only after those 40 cycles.
REQ-039 Push 5 commands back-to-back while idle -> cmd_ready_o=0 after the 4th is held; 5th accepted after the first pop; all 5 emitted in order.
REQ-040 LCD_INIT_EN; reset, then push {1,0x55} at cycle 0 -> EN idle for 20 cycles; bytes 0x38, 0x0C, 0x01, 0x06 emitted first, then 0x55.
REQ-041 Assert rst_i during PULSE with 2 commands queued -> EN=0 the next cycle; o_io_lcd=12'h800; FIFO empty; cmd_ready_o=1.
REQ-042 Push and pop in the same cycle at count 3 -> count stays 3; the pushed entry is emitted after the two older entries.

Source files
------------

// File: rtl/lcd_seq.sv
// lcd_seq: HD44780-style LCD bus sequencer with a 4-entry command FIFO.
// Each command is driven on the bus through four phases: SETUP (EN low),
// PULSE (EN high), HOLD (EN low), and EXEC (wait for the LCD to finish).
// Optional build macro LCD_INIT_EN adds two things:
//   - a power-up wait, and
//   - a built-in init sequence (0x38, 0x0C, 0x01, 0x06) that runs before
//     any queued command is served.
module lcd_seq #(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2500,
    parameter int T_EXEC_LONG = 100000,
    parameter int T_POWERUP   = 2000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    input  logic        cmd_rs_i,
    input  logic [7:0]  cmd_data_i,
    output logic        cmd_ready_o,
    output logic        busy_o,
    output logic [11:0] o_io_lcd
);

    // Size the shared down-counter for the largest wait, but never below 20 bits.
    localparam int MAX_AB = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_CD = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int MAX_EF = (T_EXEC_LONG > T_POWERUP) ? T_EXEC_LONG : T_POWERUP;
    localparam int MAX_AD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAXP   = (MAX_AD > MAX_EF) ? MAX_AD : MAX_EF;
    localparam int CW_RAW = $clog2(MAXP + 1);
    localparam int CW     = (CW_RAW > 20) ? CW_RAW : 20;

    // The counter runs from N-1 down to 0, so a phase lasts N cycles.
    // A parameter value of 0 is treated as 1.
    function automatic logic [CW-1:0] loadVal(input int p);
        if (p <= 1) begin
            return '0;
        end
        return CW'(p - 1);
    endfunction

    localparam logic [CW-1:0] SETUP_LOAD = loadVal(T_SETUP);
    localparam logic [CW-1:0] PULSE_LOAD = loadVal(T_PULSE);
    localparam logic [CW-1:0] HOLD_LOAD  = loadVal(T_HOLD);
    localparam logic [CW-1:0] EXEC_LOAD  = loadVal(T_EXEC);
    localparam logic [CW-1:0] LONG_LOAD  = loadVal(T_EXEC_LONG);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_PULSE    = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_EXEC     = 3'd4;
`ifdef LCD_INIT_EN
    localparam logic [2:0] S_PWR_WAIT = 3'd5;
    localparam logic [2:0] S_INIT     = 3'd6;
    localparam logic [2:0] S_RESET    = S_PWR_WAIT;

    // PWR_WAIT spends its first cycle arming the counter, so the counter is
    // loaded two short of T_POWERUP. That keeps the total wait at exactly
    // T_POWERUP cycles.
    localparam logic [CW-1:0] PWR_LOAD = (T_POWERUP <= 2) ? '0 : CW'(T_POWERUP - 2);
`else
    localparam logic [2:0] S_RESET    = S_IDLE;
`endif

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rs;
    logic [7:0]    r_data;

    logic [8:0]    r_mem [4];
    logic [1:0]    r_wrPtr;
    logic [1:0]    r_rdPtr;
    logic [2:0]    r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_en;
    logic          w_long;
    logic [8:0]    w_head;

`ifdef LCD_INIT_EN
    logic          r_pwrArmed;
    logic [1:0]    r_initIdx;
    logic          r_initDone;
    logic [7:0]    w_initByte;

    // Fixed init table: 8-bit bus/2 lines, display on, clear, entry mode.
    always_comb begin
        w_initByte = 8'h38;
        case (r_initIdx)
            2'd0:    w_initByte = 8'h38;
            2'd1:    w_initByte = 8'h0C;
            2'd2:    w_initByte = 8'h01;
            default: w_initByte = 8'h06;
        endcase
    end
`endif

    // IDLE is only reachable once init is finished, so IDLE with a non-empty
    // FIFO is the single pop point.
    assign w_push      = cmd_valid_i && (r_count != 3'd4);
    assign w_pop       = (r_state == S_IDLE) && (r_count != 3'd0);
    assign w_head      = r_mem[r_rdPtr];
    assign w_en        = (r_state == S_PULSE);
    assign w_long      = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));
    assign cmd_ready_o = (r_count != 3'd4);
    assign busy_o      = (r_state != S_IDLE) || (r_count != 3'd0);
    assign o_io_lcd    = {1'b1, w_en, r_rs, 1'b0, r_data};

    // FIFO storage. It holds no reset because the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {cmd_rs_i, cmd_data_i};
        end
    end

    // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wrPtr <= 2'd0;
            r_rdPtr <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bus sequencer. RS/DATA are latched only when a command starts, so they
    // stay stable from SETUP through EXEC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_RESET;
            r_cnt      <= '0;
            r_rs       <= 1'b0;
            r_data     <= 8'h00;
`ifdef LCD_INIT_EN
            r_pwrArmed <= 1'b0;
            r_initIdx  <= 2'd0;
            r_initDone <= 1'b0;
`endif
        end else begin
            case (r_state)
`ifdef LCD_INIT_EN
                S_PWR_WAIT: begin
                    if (!r_pwrArmed) begin
                        r_pwrArmed <= 1'b1;
                        if (T_POWERUP <= 1) begin
                            r_state <= S_INIT;
                        end else begin
                            r_cnt <= PWR_LOAD;
                        end
                    end else if (r_cnt == '0) begin
                        r_state <= S_INIT;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_INIT: begin
                    r_rs    <= 1'b0;
                    r_data  <= w_initByte;
                    r_cnt   <= SETUP_LOAD;
                    r_state <= S_SETUP;
                end
`endif
                S_IDLE: begin
                    if (w_pop) begin
                        r_rs    <= w_head[8];
                        r_data  <= w_head[7:0];
                        r_cnt   <= SETUP_LOAD;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= PULSE_LOAD;
                        r_state <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= HOLD_LOAD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= w_long ? LONG_LOAD : EXEC_LOAD;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
`ifdef LCD_INIT_EN
                        if (r_initDone) begin
                            r_state <= S_IDLE;
                        end else if (r_initIdx == 2'd3) begin
                            r_initDone <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_initIdx <= r_initIdx + 2'd1;
                            r_state   <= S_INIT;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_seq.sv
// tb_lcd_seq: directed, self-checking bench for lcd_seq.
// It uses short timing parameters and hand-computed cycle numbers.
// Cycle k is the k-th clock period after a stimulus starts.
// Inputs change, and outputs are sampled, at the falling edge in the middle of the cycle.
module tb_lcd_seq;

    logic        clk;
    logic        rst;
    logic        cmdValid;
    logic        cmdRs;
    logic [7:0]  cmdData;
    logic        cmdReady;
    logic        busy;
    logic [11:0] lcd;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [8:0] emitted [$];
    logic       monPrevEn = 1'b0;

    lcd_seq #(
        .T_SETUP    (2),
        .T_PULSE    (3),
        .T_HOLD     (2),
        .T_EXEC     (10),
        .T_EXEC_LONG(40),
        .T_POWERUP  (20)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmdValid),
        .cmd_rs_i   (cmdRs),
        .cmd_data_i (cmdData),
        .cmd_ready_o(cmdReady),
        .busy_o     (busy),
        .o_io_lcd   (lcd)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log {RS, DATA} every time EN rises, to check emission order.
    always @(negedge clk) begin
        if (lcd[10] && !monPrevEn) begin
            emitted.push_back(lcd[9:0] >> 1 == 0 ? {lcd[9], lcd[7:0]} : {lcd[9], lcd[7:0]});
        end
        monPrevEn <= lcd[10];
    end

    // Global safety limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic rs, input logic [7:0] d);
        cmdValid = v;
        cmdRs    = rs;
        cmdData  = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n;
        n = 0;
        while (busy && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    // Directed sequence of tests.
    initial begin
        logic [7:0] offerData [7];
        int         offerRel  [7];
        int         accCyc    [7];
        int         idx;
        int         rise1;
        int         rise2;
        logic       prevEn;
        logic [8:0] expInit [5];

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        tick();
        tick();

        // Reset state.
        doReset();
        checkOutput("reset lcd", {20'd0, lcd}, 32'h800);
        checkOutput("reset ready", {31'd0, cmdReady}, 32'd1);
`ifdef LCD_INIT_EN
        checkOutput("reset busy", {31'd0, busy}, 32'd1);

        // Power-up wait, then the init table, then the user byte.
        emitted.delete();
        applyStimulus(1'b1, 1'b1, 8'h55);
        for (int k = 0; k < 20; k++) begin
            checkOutput($sformatf("pwr en c%0d", k), {31'd0, lcd[10]}, 32'd0);
            tick();
            applyStimulus(1'b0, 1'b0, 8'h00);
        end
        waitIdle(800, "init idle timeout");
        expInit[0] = 9'h038;
        expInit[1] = 9'h00C;
        expInit[2] = 9'h001;
        expInit[3] = 9'h006;
        expInit[4] = 9'h155;
        checkOutput("init emitted count", emitted.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < emitted.size()) begin
                checkOutput($sformatf("init byte %0d", i), {23'd0, emitted[i]}, {23'd0, expInit[i]});
            end
        end
`else
        checkOutput("reset busy", {31'd0, busy}, 32'd0);

        // Single data byte: check EN window, data latch point, and busy fall.
        applyStimulus(1'b1, 1'b1, 8'h41);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("c1 data unchanged", {24'd0, lcd[7:0]}, 32'h00);
        for (int k = 1; k <= 20; k++) begin
            checkOutput($sformatf("b41 en c%0d", k), {31'd0, lcd[10]}, {31'd0, (k >= 4 && k <= 6)});
            checkOutput($sformatf("b41 busy c%0d", k), {31'd0, busy}, {31'd0, (k < 19)});
            if (k == 2 || k == 8 || k == 18) begin
                checkOutput($sformatf("b41 data c%0d", k), {24'd0, lcd[7:0]}, 32'h41);
                checkOutput($sformatf("b41 rs c%0d", k), {31'd0, lcd[9]}, 32'd1);
                checkOutput($sformatf("b41 on c%0d", k), {31'd0, lcd[11]}, 32'd1);
            end
            tick();
        end

        // Clear command gets the long wait; the next command starts only after it.
        emitted.delete();
        applyStimulus(1'b1, 1'b0, 8'h01);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h42);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        rise1  = -1;
        rise2  = -1;
        prevEn = 1'b0;
        for (int k = 2; k <= 60; k++) begin
            if (lcd[10] && !prevEn) begin
                if (rise1 < 0) rise1 = k;
                else if (rise2 < 0) rise2 = k;
            end
            prevEn = lcd[10];
            if (k == 49) checkOutput("clr data c49", {24'd0, lcd[7:0]}, 32'h01);
            if (k == 50) checkOutput("clr next data c50", {24'd0, lcd[7:0]}, 32'h42);
            tick();
        end
        checkOutput("clr first rise", rise1, 32'd4);
        checkOutput("clr second rise", rise2, 32'd52);
        waitIdle(100, "clr idle timeout");

        // Fill the FIFO, push and pop at count 3, then block while full; check order.
        emitted.delete();
        for (int i = 0; i < 7; i++) begin
            offerData[i] = 8'h10 + 8'(i);
            accCyc[i]    = -1;
        end
        offerRel[0] = 0;  offerRel[1] = 1;  offerRel[2] = 2;  offerRel[3] = 3;
        offerRel[4] = 19; offerRel[5] = 20; offerRel[6] = 21;
        idx = 0;
        for (int k = 0; k <= 45; k++) begin
            if (idx < 7 && k >= offerRel[idx]) applyStimulus(1'b1, 1'b1, offerData[idx]);
            else applyStimulus(1'b0, 1'b0, 8'h00);
            if (k == 20) checkOutput("ready at count 3 c20", {31'd0, cmdReady}, 32'd1);
            if (k == 21) checkOutput("ready full c21", {31'd0, cmdReady}, 32'd0);
            if (cmdValid && cmdReady) begin
                accCyc[idx] = k;
                idx++;
            end
            tick();
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("pushpop accept cyc", accCyc[4], 32'd19);
        checkOutput("blocked accept cyc", accCyc[6], 32'd38);
        waitIdle(300, "fifo idle timeout");
        checkOutput("fifo emitted count", emitted.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < emitted.size()) begin
                checkOutput($sformatf("fifo order %0d", i), {23'd0, emitted[i]}, {23'd0, 1'b1, offerData[i]});
            end
        end

        // Reset during PULSE with two commands queued.
        for (int k = 0; k <= 5; k++) begin
            if (k <= 2) applyStimulus(1'b1, 1'b1, 8'h60 + 8'(k));
            else applyStimulus(1'b0, 1'b0, 8'h00);
            if (k == 5) begin
                checkOutput("pre-reset en c5", {31'd0, lcd[10]}, 32'd1);
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        checkOutput("mid reset en", {31'd0, lcd[10]}, 32'd0);
        checkOutput("mid reset lcd", {20'd0, lcd}, 32'h800);
        checkOutput("mid reset ready", {31'd0, cmdReady}, 32'd1);
        checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
        emitted.delete();
        for (int k = 0; k < 30; k++) tick();
        checkOutput("discarded cmds", emitted.size(), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
